// File: rtl/net_congestion_tracker.sv
// Per-router credit/congestion tracker: per-channel free-entry counters, totals and a
// hysteretic route preference. Define NET_CONGESTION_ERR_EN to add the sticky err_o port.
module net_congestion_tracker #(
    parameter int unsigned p_num_chans = 2,
    parameter int unsigned p_q_depth   = 2,
    parameter int unsigned p_hyst      = 1,
    localparam int unsigned c_cnt_nbits = $clog2(p_q_depth + 1),
    localparam int unsigned c_tot_nbits = $clog2(p_num_chans * p_q_depth + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [p_num_chans-1:0]             forw_send_i,
    input  logic [p_num_chans-1:0]             forw_credit_i,
    input  logic [p_num_chans-1:0]             backw_send_i,
    input  logic [p_num_chans-1:0]             backw_credit_i,
    output logic [p_num_chans*c_cnt_nbits-1:0] forw_free_o,
    output logic [p_num_chans*c_cnt_nbits-1:0] backw_free_o,
    output logic [p_num_chans-1:0]             forw_rdy_o,
    output logic [p_num_chans-1:0]             backw_rdy_o,
    output logic [c_tot_nbits-1:0]             forw_total_o,
    output logic [c_tot_nbits-1:0]             backw_total_o,
    output logic                               prefer_backw_o
`ifdef NET_CONGESTION_ERR_EN
    ,
    output logic                               err_o
`endif
);

    localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_q_depth);
    localparam logic [c_tot_nbits:0]   c_hyst  = (c_tot_nbits + 1)'(p_hyst);

    typedef enum logic [0:0] {StForw = 1'b0, StBackw = 1'b1} pref_e;

    logic [p_num_chans-1:0][c_cnt_nbits-1:0] forw_cnt_q, forw_cnt_d;
    logic [p_num_chans-1:0][c_cnt_nbits-1:0] backw_cnt_q, backw_cnt_d;
    pref_e                                   pref_q, pref_d;
    logic [c_tot_nbits:0]                    forw_tot_ext, backw_tot_ext;

    // Send and credit together cancel; each alone saturates at the ends of [0, depth].
    function automatic logic [c_cnt_nbits-1:0] cnt_next(input logic [c_cnt_nbits-1:0] cnt,
                                                         input logic send,
                                                         input logic credit);
        logic [c_cnt_nbits-1:0] nxt;
        nxt = cnt;
        if (send && !credit && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end else if (credit && !send && (cnt != c_depth)) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

    always_comb begin
        forw_cnt_d  = forw_cnt_q;
        backw_cnt_d = backw_cnt_q;
        for (int i = 0; i < int'(p_num_chans); i++) begin
            forw_cnt_d[i]  = cnt_next(forw_cnt_q[i], forw_send_i[i], forw_credit_i[i]);
            backw_cnt_d[i] = cnt_next(backw_cnt_q[i], backw_send_i[i], backw_credit_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            forw_cnt_q  <= {p_num_chans{c_depth}};
            backw_cnt_q <= {p_num_chans{c_depth}};
        end else begin
            forw_cnt_q  <= forw_cnt_d;
            backw_cnt_q <= backw_cnt_d;
        end
    end

    always_comb begin
        forw_total_o  = '0;
        backw_total_o = '0;
        forw_rdy_o    = '0;
        backw_rdy_o   = '0;
        for (int i = 0; i < int'(p_num_chans); i++) begin
            forw_total_o   = forw_total_o + c_tot_nbits'(forw_cnt_q[i]);
            backw_total_o  = backw_total_o + c_tot_nbits'(backw_cnt_q[i]);
            forw_rdy_o[i]  = (forw_cnt_q[i] != '0);
            backw_rdy_o[i] = (backw_cnt_q[i] != '0);
        end
    end

    assign forw_free_o  = forw_cnt_q;
    assign backw_free_o = backw_cnt_q;

    // One extra bit so total + hysteresis never wraps.
    assign forw_tot_ext  = {1'b0, forw_total_o};
    assign backw_tot_ext = {1'b0, backw_total_o};

    always_comb begin
        pref_d = pref_q;
        unique case (pref_q)
            StForw: begin
                if (backw_tot_ext > forw_tot_ext + c_hyst) begin
                    pref_d = StBackw;
                end
            end
            StBackw: begin
                if (forw_tot_ext > backw_tot_ext + c_hyst) begin
                    pref_d = StForw;
                end
            end
            default: pref_d = StForw;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pref_q <= StForw;
        end else begin
            pref_q <= pref_d;
        end
    end

    assign prefer_backw_o = (pref_q == StBackw);

`ifdef NET_CONGESTION_ERR_EN
    logic err_q, err_d;

    // Flags only a lone send at empty or a lone credit at full; a cancelling pair is benign.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < int'(p_num_chans); i++) begin
            if ((forw_send_i[i] && !forw_credit_i[i] && (forw_cnt_q[i] == '0)) ||
                (forw_credit_i[i] && !forw_send_i[i] && (forw_cnt_q[i] == c_depth)) ||
                (backw_send_i[i] && !backw_credit_i[i] && (backw_cnt_q[i] == '0)) ||
                (backw_credit_i[i] && !backw_send_i[i] && (backw_cnt_q[i] == c_depth))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_net_congestion_tracker.sv
// Self-checking bench for net_congestion_tracker: directed scenarios plus randomized
// traffic compared against a behavioural credit/preference model.
module tb_net_congestion_tracker;

    localparam int C = 2;
    localparam int D = 2;
    localparam int H = 1;
    localparam int W = $clog2(D + 1);
    localparam int T = $clog2(C * D + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [C-1:0]   fs, fc, bs, bc;
    logic [C*W-1:0] forw_free, backw_free;
    logic [C-1:0]   forw_rdy, backw_rdy;
    logic [T-1:0]   forw_total, backw_total;
    logic           prefer_backw;
    logic           err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int mf[C];
    int mb[C];
    bit mpref;
    bit merr;

    always #5 clk = ~clk;

    net_congestion_tracker #(
        .p_num_chans(C),
        .p_q_depth  (D),
        .p_hyst     (H)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .forw_send_i   (fs),
        .forw_credit_i (fc),
        .backw_send_i  (bs),
        .backw_credit_i(bc),
        .forw_free_o   (forw_free),
        .backw_free_o  (backw_free),
        .forw_rdy_o    (forw_rdy),
        .backw_rdy_o   (backw_rdy),
        .forw_total_o  (forw_total),
        .backw_total_o (backw_total),
        .prefer_backw_o(prefer_backw)
`ifdef NET_CONGESTION_ERR_EN
        ,
        .err_o         (err)
`endif
    );

`ifndef NET_CONGESTION_ERR_EN
    assign err = 1'b0;
`endif

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin
            mf[i] = D;
            mb[i] = D;
        end
        mpref = 1'b0;
        merr  = 1'b0;
    endfunction

    function automatic int msum(input bit backw);
        int s = 0;
        for (int i = 0; i < C; i++) s += backw ? mb[i] : mf[i];
        return s;
    endfunction

    function automatic logic [C*W-1:0] mfree(input bit backw);
        logic [C*W-1:0] v;
        for (int i = 0; i < C; i++) v[i*W +: W] = W'(backw ? mb[i] : mf[i]);
        return v;
    endfunction

    function automatic logic [C-1:0] mrdy(input bit backw);
        logic [C-1:0] v;
        for (int i = 0; i < C; i++) v[i] = ((backw ? mb[i] : mf[i]) != 0);
        return v;
    endfunction

    task automatic upd(inout int c, input logic s, input logic cr);
        if (s && !cr) begin
            if (c == 0) merr = 1'b1;
            else c--;
        end else if (cr && !s) begin
            if (c == D) merr = 1'b1;
            else c++;
        end
    endtask

    // Advance model by one edge using inputs as they stand, then step past the edge.
    task automatic tick();
        int ft, bt;
        if (!rst_n) begin
            model_reset();
        end else begin
            ft = msum(1'b0);
            bt = msum(1'b1);
            if (!mpref && (bt > ft + H)) mpref = 1'b1;
            else if (mpref && (ft > bt + H)) mpref = 1'b0;
            for (int i = 0; i < C; i++) begin
                upd(mf[i], fs[i], fc[i]);
                upd(mb[i], bs[i], bc[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fs = '0; fc = '0; bs = '0; bc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (forw_free !== {C{W'(D)}} || backw_free !== {C{W'(D)}}) begin
            failures++;
            $display("FAIL reset_free: got f=%h b=%h want %h", forw_free, backw_free, {C{W'(D)}});
        end
        checks++;
        if (forw_rdy !== 2'b11 || backw_rdy !== 2'b11 || forw_total !== T'(4) ||
            backw_total !== T'(4) || prefer_backw !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc: got rdy=%b/%b tot=%0d/%0d pref=%b err=%b want 11/11 4/4 0 0",
                     forw_rdy, backw_rdy, forw_total, backw_total, prefer_backw, err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (forw_total !== T'(4) || backw_total !== T'(4) || prefer_backw !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got tot=%0d/%0d pref=%b want 4/4 0",
                     forw_total, backw_total, prefer_backw);
        end
    endtask

    task automatic test_drain();
        do_reset();
        fs = 2'b01;
        tick();
        checks++;
        if (forw_free[0 +: W] !== W'(1)) begin
            failures++;
            $display("FAIL drain_1: got ch0=%0d want 1", forw_free[0 +: W]);
        end
        tick();
        fs = '0;
        checks++;
        if (forw_free[0 +: W] !== W'(0) || forw_rdy !== 2'b10 || forw_total !== T'(2) ||
            prefer_backw !== 1'b0) begin
            failures++;
            $display("FAIL drain_2: got ch0=%0d rdy=%b tot=%0d pref=%b want 0 10 2 0",
                     forw_free[0 +: W], forw_rdy, forw_total, prefer_backw);
        end
        tick();
        checks++;
        if (prefer_backw !== 1'b1) begin
            failures++;
            $display("FAIL drain_pref: got %b want 1", prefer_backw);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        fs = 2'b10;
        tick();
        fs = '0;
        checks++;
        if (forw_total !== T'(3) || backw_total !== T'(4)) begin
            failures++;
            $display("FAIL hyst_tot: got %0d/%0d want 3/4", forw_total, backw_total);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (prefer_backw !== 1'b0) begin
                failures++;
                $display("FAIL hyst_hold%0d: got %b want 0", k, prefer_backw);
            end
        end
        bs = 2'b01;
        tick();
        bs = '0;
        fc = 2'b10;
        tick();
        tick();
        fc = '0;
        tick();
        checks++;
        if (forw_total !== T'(4) || backw_total !== T'(3) || prefer_backw !== 1'b0) begin
            failures++;
            $display("FAIL hyst_back: got tot=%0d/%0d pref=%b want 4/3 0",
                     forw_total, backw_total, prefer_backw);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fs = 2'b10;
        tick();
        fc = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (forw_free[W +: W] !== W'(1) || forw_total !== T'(3)) begin
                failures++;
                $display("FAIL simul%0d: got ch1=%0d tot=%0d want 1 3",
                         k, forw_free[W +: W], forw_total);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        fs = 2'b01;
        tick();
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL sat_noerr: got err=%b want 0", err);
        end
        tick();
        fs = '0;
        checks++;
        if (forw_free[0 +: W] !== W'(0)) begin
            failures++;
            $display("FAIL sat_under: got ch0=%0d want 0", forw_free[0 +: W]);
        end
        fc = 2'b10;
        tick();
        fc = '0;
        checks++;
        if (forw_free[W +: W] !== W'(2)) begin
            failures++;
            $display("FAIL sat_over: got ch1=%0d want 2", forw_free[W +: W]);
        end
`ifdef NET_CONGESTION_ERR_EN
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL sat_err: got err=%b want 1", err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL sat_errclr: got err=%b want 0", err);
        end
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        fs = 2'b01;
        tick();
        tick();
        fs = 2'b10;
        tick();
        fs = '0;
        tick();
        checks++;
        if (forw_free !== {W'(1), W'(0)} || prefer_backw !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got free=%h pref=%b want %h 1",
                     forw_free, prefer_backw, {W'(1), W'(0)});
        end
        fs = 2'b11; bs = 2'b11;
        rst_n = 1'b0;
        #2;
        checks++;
        if (forw_free !== {C{W'(D)}} || forw_total !== T'(4) || prefer_backw !== 1'b0) begin
            failures++;
            $display("FAIL mid_async: got free=%h tot=%0d pref=%b want %h 4 0",
                     forw_free, forw_total, prefer_backw, {C{W'(D)}});
        end
        tick();
        tick();
        checks++;
        if (forw_free !== {C{W'(D)}} || backw_free !== {C{W'(D)}}) begin
            failures++;
            $display("FAIL mid_ignore: got f=%h b=%h want %h", forw_free, backw_free, {C{W'(D)}});
        end
        #2;
        rst_n = 1'b1;
        idle_inputs();
        fs = 2'b01;
        model_reset();
        tick();
        fs = '0;
        checks++;
        if (forw_free[0 +: W] !== W'(1)) begin
            failures++;
            $display("FAIL mid_first: got ch0=%0d want 1", forw_free[0 +: W]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            fs = C'($urandom);
            fc = C'($urandom);
            bs = C'($urandom);
            bc = C'($urandom);
            // Bias toward one direction in stretches so preference swings both ways.
            if ((n / 40) % 2 == 0) fc = fc & C'($urandom);
            else bc = bc & C'($urandom);
            tick();
            checks++;
            if (forw_free !== mfree(1'b0) || backw_free !== mfree(1'b1) ||
                forw_rdy !== mrdy(1'b0) || backw_rdy !== mrdy(1'b1) ||
                forw_total !== T'(msum(1'b0)) || backw_total !== T'(msum(1'b1)) ||
                prefer_backw !== mpref
`ifdef NET_CONGESTION_ERR_EN
                || err !== merr
`endif
                ) begin
                failures++;
                $display("FAIL rand%0d: got f=%h b=%h tot=%0d/%0d pref=%b err=%b want f=%h b=%h tot=%0d/%0d pref=%b err=%b",
                         n, forw_free, backw_free, forw_total, backw_total, prefer_backw, err,
                         mfree(1'b0), mfree(1'b1), msum(1'b0), msum(1'b1), mpref, merr);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_hysteresis();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
